// File: rtl/sync_fifo_pkg.sv
// Shared widths, read-mode constants and parameter legality check for sync_fifo_flex.
package sync_fifo_pkg;

    localparam int unsigned MODE_REG  = 0;
    localparam int unsigned MODE_FWFT = 1;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy needs one extra bit to represent a completely full FIFO.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_params_ok(input int unsigned depth,
                                          input int unsigned af_thresh,
                                          input int unsigned ae_thresh,
                                          input int unsigned fwft);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh <= depth - 1) && (fwft <= MODE_FWFT);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, contents never reset.
module sync_fifo_ram #(
    parameter  int unsigned DEPTH      = 16,
    parameter  int unsigned DATA_WIDTH = 8,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost flags and registered/FWFT read modes.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 1,
    parameter int unsigned FWFT       = MODE_REG
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                        err_clr,
    output logic                        overflow,
    output logic                        underflow,
`endif
    input  logic                        w_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        r_en,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_w(DEPTH)-1:0]     count
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    if (!fifo_params_ok(DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_bad_params
        $error("sync_fifo_flex: illegal parameter combination");
    end

    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  wr_acc, rd_acc;

    // Acceptance is judged only on the registered flags from the start of the cycle.
    assign wr_acc = w_en && !full_q;
    assign rd_acc = r_en && !empty_q;

    sync_fifo_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc && rst_n),
        .waddr_i (wptr_q),
        .wdata_i (data_in),
        .raddr_i (rptr_q),
        .rdata_o (rdata)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + AW'(1);
            dout_d = rdata;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
        af_d    = (count_d >= CW'(AF_THRESH));
        ae_d    = (count_d <= CW'(AE_THRESH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            dout_q  <= dout_d;
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;

    // FWFT shows the head entry directly; it reads as zero while nothing is stored.
    if (FWFT == MODE_FWFT) begin : g_fwft
        assign data_out = empty_q ? '0 : rdata;
    end else begin : g_reg
        assign data_out = dout_q;
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        ovf_d = (w_en && full_q)  || (ovf_q && !err_clr);
        unf_d = (r_en && empty_q) || (unf_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: registered and FWFT instances share stimulus, checked against a queue model.
// Error-flag checks are compiled when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_flex;

    localparam int unsigned D  = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n, w_en, r_en, err_clr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] r_dout, f_dout;
    logic          r_full, r_empty, r_af, r_ae, f_full, f_empty, f_af, f_ae;
    logic [CW-1:0] r_count, f_count;
`ifdef FIFO_ERR_FLAGS_EN
    logic          r_ovf, r_unf, f_ovf, f_unf;
`endif

    always #5 clk = ~clk;

    sync_fifo_flex #(.DEPTH(D), .DATA_WIDTH(DW), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr(err_clr), .overflow(r_ovf), .underflow(r_unf),
`endif
        .w_en(w_en), .data_in(data_in), .r_en(r_en), .data_out(r_dout),
        .full(r_full), .empty(r_empty), .almost_full(r_af), .almost_empty(r_ae), .count(r_count)
    );

    sync_fifo_flex #(.DEPTH(D), .DATA_WIDTH(DW), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr(err_clr), .overflow(f_ovf), .underflow(f_unf),
`endif
        .w_en(w_en), .data_in(data_in), .r_en(r_en), .data_out(f_dout),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of stored words plus the last value popped.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dreg;
    logic          m_ovf, m_unf;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit was_full, was_empty;
        if (!rst_n) begin
            mq.delete();
            m_dreg = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            was_full  = (mq.size() == D);
            was_empty = (mq.size() == 0);
            m_ovf = (w_en && was_full)  || (m_ovf && !err_clr);
            m_unf = (r_en && was_empty) || (m_unf && !err_clr);
            if (r_en && !was_empty) m_dreg = mq.pop_front();
            if (w_en && !was_full)  mq.push_back(data_in);
        end
    endtask

    task automatic compare_model();
        int sz;
        sz = mq.size();
        check("m_count",     32'(r_count), 32'(sz));
        check("m_empty",     32'(r_empty), 32'(sz == 0));
        check("m_full",      32'(r_full),  32'(sz == D));
        check("m_af",        32'(r_af),    32'(sz >= 6));
        check("m_ae",        32'(r_ae),    32'(sz <= 2));
        check("m_dout_reg",  32'(r_dout),  32'(m_dreg));
        check("m_fwft_cnt",  32'(f_count), 32'(sz));
        check("m_fwft_emp",  32'(f_empty), 32'(sz == 0));
        check("m_fwft_dout", 32'(f_dout),  32'((sz != 0) ? mq[0] : 8'h00));
`ifdef FIFO_ERR_FLAGS_EN
        check("m_ovf",       32'(r_ovf),   32'(m_ovf));
        check("m_unf",       32'(r_unf),   32'(m_unf));
        check("m_fwft_ovf",  32'(f_ovf),   32'(m_ovf));
        check("m_fwft_unf",  32'(f_unf),   32'(m_unf));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic set_in(input logic rn, input logic we, input logic re, input logic [DW-1:0] d);
        rst_n = rn; w_en = we; r_en = re; data_in = d;
    endtask

    typedef struct {
        logic          rn, we, re;
        logic [DW-1:0] din;
        int            cnt;
        logic          emp, ful, ae, af;
        logic [DW-1:0] dreg;
    } vec_t;

    vec_t tv[8];
    logic [DW-1:0] saved;

    initial begin
        m_dreg = '0; m_ovf = 1'b0; m_unf = 1'b0;
        err_clr = 1'b0;
        set_in(1'b0, 1'b1, 1'b0, 8'h11);

        // Reset with writes pending, then read-from-empty and mixed pairs at low occupancy.
        tv[0] = '{1'b0, 1'b1, 1'b0, 8'h11, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[1] = '{1'b0, 1'b1, 1'b0, 8'h22, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[2] = '{1'b1, 1'b1, 1'b1, 8'h01, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[3] = '{1'b1, 1'b1, 1'b0, 8'h02, 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tv[4] = '{1'b1, 1'b1, 1'b0, 8'h03, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[5] = '{1'b1, 1'b1, 1'b1, 8'h04, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        tv[6] = '{1'b1, 1'b0, 1'b1, 8'h05, 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02};
        tv[7] = '{1'b0, 1'b1, 1'b1, 8'h55, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        for (int i = 0; i < 8; i++) begin
            set_in(tv[i].rn, tv[i].we, tv[i].re, tv[i].din);
            tick();
            check("tv_count", 32'(r_count), 32'(tv[i].cnt));
            check("tv_empty", 32'(r_empty), 32'(tv[i].emp));
            check("tv_full",  32'(r_full),  32'(tv[i].ful));
            check("tv_ae",    32'(r_ae),    32'(tv[i].ae));
            check("tv_af",    32'(r_af),    32'(tv[i].af));
            check("tv_dout",  32'(r_dout),  32'(tv[i].dreg));
        end

        // Fill 1..8 then drain in order.
        for (int i = 1; i <= 8; i++) begin
            set_in(1'b1, 1'b1, 1'b0, DW'(i));
            tick();
            check("fill_count", 32'(r_count), 32'(i));
            check("fill_af",    32'(r_af),    32'(i >= 6));
            check("fill_full",  32'(r_full),  32'(i == 8));
        end
        for (int i = 1; i <= 8; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 8'h00);
            tick();
            check("drain_data", 32'(r_dout), 32'(i));
            check("drain_ae",   32'(r_ae),   32'((8 - i) <= 2));
        end
        check("drain_empty", 32'(r_empty), 32'(1));

        // Full with both requests: write is refused, read proceeds.
        for (int i = 1; i <= 8; i++) begin
            set_in(1'b1, 1'b1, 1'b0, DW'(8'h10 + i));
            tick();
        end
        set_in(1'b1, 1'b1, 1'b1, 8'h99);
        tick();
        check("full_both_count", 32'(r_count), 32'(7));
        check("full_both_full",  32'(r_full),  32'(0));
        check("full_both_dout",  32'(r_dout),  32'(8'h11));

        // Count of 4 with both requests stays at 4.
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 1'b1, 1'b0, DW'(8'h20 + i));
            tick();
        end
        set_in(1'b1, 1'b1, 1'b1, 8'h25);
        tick();
        check("mid_both_count", 32'(r_count), 32'(4));

        // FWFT: first word visible without a read, pop empties.
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 8'hA5);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 8'h00);
        check("fwft_first_dout",  32'(f_dout),  32'(8'hA5));
        check("fwft_first_empty", 32'(f_empty), 32'(0));
        tick();
        check("fwft_hold_dout", 32'(f_dout), 32'(8'hA5));
        set_in(1'b1, 1'b0, 1'b1, 8'h00);
        tick();
        check("fwft_pop_empty", 32'(f_empty), 32'(1));

        // 20 write/read pairs cross the pointer wrap several times.
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 20; i++) begin
            saved = DW'($urandom);
            set_in(1'b1, 1'b1, 1'b0, saved);
            tick();
            check("wrap_fwft", 32'(f_dout), 32'(saved));
            set_in(1'b1, 1'b0, 1'b1, 8'h00);
            tick();
            check("wrap_reg", 32'(r_dout), 32'(saved));
        end

`ifdef FIFO_ERR_FLAGS_EN
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b1, 1'b0, DW'(8'h40 + i));
            tick();
        end
        check("err_pre_ovf", 32'(r_ovf), 32'(0));
        set_in(1'b1, 1'b1, 1'b0, 8'hEE);
        tick();
        check("err_ovf_set", 32'(r_ovf), 32'(1));
        set_in(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        check("err_ovf_held", 32'(r_ovf), 32'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_ovf_clr", 32'(r_ovf), 32'(0));
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 8'h00);
        tick();
        check("err_unf_set", 32'(r_unf), 32'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_unf_set_wins", 32'(r_unf), 32'(1));
`endif

        // Random traffic with occasional resets and error clears.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom), DW'($urandom));
            err_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        err_clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
